// File: rtl/hazard_unit.sv
// Pipeline interlock and forwarding controller: shadow scoreboard of EX/MEM/WB destinations driving stall, bubble, flush and operand-forward selects.
// Optional FORWARD_EN macro: when defined, only load-use stalls and EX operands are forwarded from MEM/WB; otherwise full EX/MEM interlock.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      PR_IFID_Inst,
    input  logic             EX_BranchTaken,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic [1:0]       Fwd_A,
    output logic [1:0]       Fwd_B,
    output logic [1:0]       Hazard_State,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
        logic       is_beq;
        logic [4:0] src_a;
        logic [4:0] src_b;
    } shadow_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } hz_state_t;

    shadow_t   id_ent, ex_q, mem_q, wb_q;
    hz_state_t state_q;
    logic      taken, hazard, stall;

    wire [5:0] opcode = PR_IFID_Inst[31:26];
    wire [4:0] rs     = PR_IFID_Inst[25:21];
    wire [4:0] rt     = PR_IFID_Inst[20:16];
    wire [4:0] rd     = PR_IFID_Inst[15:11];
    wire [5:0] funct  = PR_IFID_Inst[5:0];

    // $0 is encoded as "no register": it never equals a nonzero dest.
    always_comb begin
        id_ent       = '0;
        id_ent.valid = 1'b1;
        case (opcode)
            6'h00: begin
                id_ent.dest  = rd;
                id_ent.src_b = rt;
                if (funct[5:2] != 4'd0)
                    id_ent.src_a = rs;
            end
            6'h23: begin
                id_ent.dest    = rt;
                id_ent.is_load = 1'b1;
                id_ent.src_a   = rs;
            end
            6'h2B: begin
                id_ent.src_a = rs;
                id_ent.src_b = rt;
            end
            6'h04: begin
                id_ent.is_beq = 1'b1;
                id_ent.src_a  = rs;
                id_ent.src_b  = rt;
            end
            default: ;
        endcase
    end

    function automatic logic dep_on(input shadow_t e, input logic [4:0] a, input logic [4:0] b);
        return e.valid && (e.dest != 5'd0) && ((e.dest == a) || (e.dest == b));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] s, input shadow_t m, input shadow_t w);
        if (s != 5'd0 && m.valid && !m.is_load && m.dest == s)
            return 2'b10;
        else if (s != 5'd0 && w.valid && w.dest == s)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign taken = EX_BranchTaken && ex_q.valid && ex_q.is_beq;

`ifdef FORWARD_EN
    assign hazard = ex_q.is_load && dep_on(ex_q, id_ent.src_a, id_ent.src_b);
    assign Fwd_A  = fwd_sel(ex_q.src_a, mem_q, wb_q);
    assign Fwd_B  = fwd_sel(ex_q.src_b, mem_q, wb_q);
`else
    assign hazard = dep_on(ex_q, id_ent.src_a, id_ent.src_b)
                 || dep_on(mem_q, id_ent.src_a, id_ent.src_b);
    assign Fwd_A  = 2'b00;
    assign Fwd_B  = 2'b00;
`endif

    // A taken branch squashes the ID instruction, so its hazard is moot.
    assign stall        = hazard && !taken;
    assign PC_Write     = !stall;
    assign IFID_Write   = !stall;
    assign IDEX_Bubble  = stall;
    assign IFID_Flush   = taken;
    assign IDEX_Flush   = taken;
    assign Hazard_State = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            state_q     <= ST_RUN;
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else begin
            ex_q  <= (stall || taken) ? shadow_t'('0) : id_ent;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (taken)
                state_q <= ST_FLUSH;
            else if (stall)
                state_q <= ST_STALL;
            else
                state_q <= ST_RUN;
            if (stall && Stall_Count != {CNT_W{1'b1}})
                Stall_Count <= Stall_Count + CNT_W'(1);
            if (taken && Flush_Count != {CNT_W{1'b1}})
                Flush_Count <= Flush_Count + CNT_W'(1);
        end
    end

    logic unused_sink;
    assign unused_sink = ^{PR_IFID_Inst[10:6], mem_q, wb_q, ex_q.is_load, ex_q.src_a, ex_q.src_b};

endmodule
